// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the ARM-subset decode/issue stage:
//               instruction field enums, EXE command codes, the control
//               bundle carried to EXE and the condition-field evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    // Instruction class held in instr[27:26]
    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    // Data-processing opcode held in instr[24:21]
    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_RSB = 4'b0011,
        OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111,
        OP_TST = 4'b1000, OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_CMN = 4'b1011,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110, OP_MVN = 4'b1111
    } opcode_e;

    // Condition field held in instr[31:28]
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    // ALU command codes understood by EXE
    localparam logic [3:0] c_exe_nop    = 4'b0000;
    localparam logic [3:0] c_exe_mov    = 4'b0001;
    localparam logic [3:0] c_exe_add    = 4'b0010;
    localparam logic [3:0] c_exe_adc    = 4'b0011;
    localparam logic [3:0] c_exe_sub    = 4'b0100;
    localparam logic [3:0] c_exe_sbc    = 4'b0101;
    localparam logic [3:0] c_exe_and    = 4'b0110;
    localparam logic [3:0] c_exe_orr    = 4'b0111;
    localparam logic [3:0] c_exe_eor    = 4'b1000;
    localparam logic [3:0] c_exe_mvn    = 4'b1001;
    localparam logic [3:0] c_exe_ldst   = c_exe_add;   // address = Rn + offset
    localparam logic [3:0] c_exe_branch = c_exe_nop;

    // Control half of the ID/EXE bundle; all-zero is a bubble
    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    // Evaluate an ARM condition field against {N,Z,C,V}; NV never passes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v, r;
        {n, z, c, v} = sr;
        case (cond_e'(cond))
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// Module      : id_regfile
// Description : NUM_REGS x DATA_W register file, two asynchronous read ports,
//               one synchronous write port, asynchronous clear. Indices at or
//               above NUM_REGS read as zero and ignore writes.
//               Optional build macro WB_BYPASS_EN: a read of the register
//               being written in the same cycle returns the write data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_raddr1,
    input  logic [3:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_wb_en,
    input  logic [3:0]        i_wb_dest,
    input  logic [DATA_W-1:0] i_wb_data
);

    // Full 16-slot view of the file; unimplemented slots are tied to zero
    logic [DATA_W-1:0] w_q [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
        if (gi < NUM_REGS) begin : g_reg
            logic [DATA_W-1:0] r_q;

            // Storage for one implemented register, cleared asynchronously
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_wb_en && (i_wb_dest == 4'(gi))) begin
                    r_q <= i_wb_data;
                end
            end

            assign w_q[gi] = r_q;
        end else begin : g_none
            assign w_q[gi] = '0;
        end
    end

`ifdef WB_BYPASS_EN
    localparam logic [4:0] c_num_regs = 5'(NUM_REGS);

    logic w_byp1, w_byp2;

    assign w_byp1 = i_wb_en && (i_wb_dest == i_raddr1) && ({1'b0, i_raddr1} < c_num_regs);
    assign w_byp2 = i_wb_en && (i_wb_dest == i_raddr2) && ({1'b0, i_raddr2} < c_num_regs);

    assign o_rdata1 = w_byp1 ? i_wb_data : w_q[i_raddr1];
    assign o_rdata2 = w_byp2 ? i_wb_data : w_q[i_raddr2];
`else
    // Same-cycle write is not visible; the hazard unit stalls for WB->ID
    assign o_rdata1 = w_q[i_raddr1];
    assign o_rdata2 = w_q[i_raddr2];
`endif

endmodule

`default_nettype wire

// File: rtl/decode_issue_stage.sv
// ============================================================================
// Module      : decode_issue_stage
// Description : ARM-subset decode stage with integrated ID/EXE register.
//               Decodes instr, reads the register file, evaluates the
//               condition field against SR and issues a valid-tagged bundle
//               to EXE one cycle later. Supports freeze (hold), flush and
//               hazard bubbles. Optional build macro WB_BYPASS_EN enables
//               write-back to read forwarding inside the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              hazard,
    input  logic              freeze,
    input  logic              flush,
    input  logic [3:0]        sr,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic [3:0]        ex_exe_cmd,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_operand,
    output logic [23:0]       ex_signed_imm_24,
    output logic [3:0]        ex_dest
);

    mode_e             w_mode;
    logic              w_store;
    ctrl_t             w_ctrl;
    logic              w_cond_ok;
    logic              w_load;
    logic [DATA_W-1:0] w_val_rn;
    logic [DATA_W-1:0] w_val_rm;

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_val_rn;
    logic [DATA_W-1:0] r_val_rm;
    logic              r_imm;
    logic [11:0]       r_shift_operand;
    logic [23:0]       r_signed_imm_24;
    logic [3:0]        r_dest;

    assign w_mode  = mode_e'(instr[27:26]);
    assign w_store = (w_mode == MODE_MEM) && !instr[20];

    // A store reads Rd as its data operand instead of Rm
    assign src1    = instr[19:16];
    assign src2    = w_store ? instr[15:12] : instr[3:0];
    assign two_src = w_store | ~instr[25];

    // Decode the control half of the bundle from mode/opcode/S
    always_comb begin
        w_ctrl = '0;
        case (w_mode)
            MODE_DP: begin
                w_ctrl.wb_en = 1'b1;
                w_ctrl.s     = instr[20];
                case (opcode_e'(instr[24:21]))
                    OP_MOV:  w_ctrl.exe_cmd = c_exe_mov;
                    OP_MVN:  w_ctrl.exe_cmd = c_exe_mvn;
                    OP_ADD:  w_ctrl.exe_cmd = c_exe_add;
                    OP_ADC:  w_ctrl.exe_cmd = c_exe_adc;
                    OP_SUB:  w_ctrl.exe_cmd = c_exe_sub;
                    OP_SBC:  w_ctrl.exe_cmd = c_exe_sbc;
                    OP_AND:  w_ctrl.exe_cmd = c_exe_and;
                    OP_ORR:  w_ctrl.exe_cmd = c_exe_orr;
                    OP_EOR:  w_ctrl.exe_cmd = c_exe_eor;
                    // Compare/test only produce flags
                    OP_CMP: begin
                        w_ctrl.exe_cmd = c_exe_sub;
                        w_ctrl.wb_en   = 1'b0;
                        w_ctrl.s       = 1'b1;
                    end
                    OP_TST: begin
                        w_ctrl.exe_cmd = c_exe_and;
                        w_ctrl.wb_en   = 1'b0;
                        w_ctrl.s       = 1'b1;
                    end
                    default: w_ctrl = '0;
                endcase
            end
            // Loads and stores never update flags; instr[20] selects direction
            MODE_MEM: begin
                w_ctrl.exe_cmd  = c_exe_ldst;
                w_ctrl.wb_en    = instr[20];
                w_ctrl.mem_r_en = instr[20];
                w_ctrl.mem_w_en = ~instr[20];
            end
            MODE_BR: begin
                w_ctrl.b       = 1'b1;
                w_ctrl.exe_cmd = c_exe_branch;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign w_cond_ok = cond_pass(instr[31:28], sr);
    assign w_load    = ~flush & ~hazard & instr_valid & w_cond_ok;

    id_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_raddr1  (src1),
        .i_raddr2  (src2),
        .o_rdata1  (w_val_rn),
        .o_rdata2  (w_val_rm),
        .i_wb_en   (wb_en),
        .i_wb_dest (wb_dest),
        .i_wb_data (wb_data)
    );

    // ID/EXE register: freeze holds, otherwise issue a live bundle or a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid         <= 1'b0;
            r_ctrl          <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
        end else if (!freeze) begin
            r_valid         <= w_load;
            r_ctrl          <= w_load ? w_ctrl : '0;
            r_val_rn        <= w_val_rn;
            r_val_rm        <= w_val_rm;
            r_imm           <= instr[25];
            r_shift_operand <= instr[11:0];
            r_signed_imm_24 <= instr[23:0];
            r_dest          <= instr[15:12];
        end
    end

    assign ex_valid         = r_valid;
    assign ex_wb_en         = r_ctrl.wb_en;
    assign ex_mem_r_en      = r_ctrl.mem_r_en;
    assign ex_mem_w_en      = r_ctrl.mem_w_en;
    assign ex_b             = r_ctrl.b;
    assign ex_s             = r_ctrl.s;
    assign ex_exe_cmd       = r_ctrl.exe_cmd;
    assign ex_val_rn        = r_val_rn;
    assign ex_val_rm        = r_val_rm;
    assign ex_imm           = r_imm;
    assign ex_shift_operand = r_shift_operand;
    assign ex_signed_imm_24 = r_signed_imm_24;
    assign ex_dest          = r_dest;

endmodule

`default_nettype wire
